// File: rtl/sata_rx_prim_decode_if.sv
// ---------------------------------------------------------------------------
// sata_rx_prim_decode_if
//   Bundle between the PHY receive path and the link layer, passing through
//   the primitive decoder.
//
//   PHY side   : linkup, rxdata[31:0], rxdatak
//   Link side  : prim_vld, prim_code[3:0], data_vld, data_out[31:0],
//                cont_active, prim_err
//   Statistics : err_cnt[ERRCNT_W-1:0], align_cnt[ALIGNCNT_W-1:0]
//
//   Modports:
//     master - the upstream side (PHY model / bench). It drives the receive
//              stream and observes the decoded results.
//     slave  - the decoder. It consumes the stream and drives the results.
// ---------------------------------------------------------------------------
interface sata_rx_prim_decode_if #(
  parameter int ERRCNT_W   = 8,
  parameter int ALIGNCNT_W = 16
) ();

  logic                  linkup;
  logic [31:0]           rxdata;
  logic                  rxdatak;

  logic                  prim_vld;
  logic [3:0]            prim_code;
  logic                  data_vld;
  logic [31:0]           data_out;
  logic                  cont_active;
  logic                  prim_err;
  logic [ERRCNT_W-1:0]   err_cnt;
  logic [ALIGNCNT_W-1:0] align_cnt;

  modport master (
    output linkup, rxdata, rxdatak,
    input  prim_vld, prim_code, data_vld, data_out,
    input  cont_active, prim_err, err_cnt, align_cnt
  );

  modport slave (
    input  linkup, rxdata, rxdatak,
    output prim_vld, prim_code, data_vld, data_out,
    output cont_active, prim_err, err_cnt, align_cnt
  );

endinterface

// File: rtl/sata_rx_prim_decode.sv
// ---------------------------------------------------------------------------
// sata_rx_prim_decode
//   Receive-side primitive decoder sitting directly behind one PHY port.
//   Every dword received on clk_75m is classified as a SATA primitive or as
//   FIS data. ALIGNs are dropped and counted. CONT runs are expanded so the
//   link layer sees exactly one event per dword: the primitive that preceded
//   the CONT is repeated for every scrambled junk dword that follows it.
//   Results are registered, so input at cycle n shows up at cycle n+1.
//
// Ports
//   clk_75m   - PHY clock, the only clock
//   host_rst  - synchronous, active-high reset
//   bus       - sata_rx_prim_decode_if.slave
//               in : linkup, rxdata[31:0] (byte0 in [7:0]), rxdatak
//               out: prim_vld, prim_code[3:0], data_vld, data_out[31:0],
//                    cont_active, prim_err (1-cycle pulse),
//                    err_cnt (saturating prim_err count),
//                    align_cnt (saturating dropped-ALIGN count)
// ---------------------------------------------------------------------------
module sata_rx_prim_decode #(
  parameter int C_ERRCNT_W   = 8,
  parameter int C_ALIGNCNT_W = 16
) (
  input  logic                  clk_75m,
  input  logic                  host_rst,
  sata_rx_prim_decode_if.slave  bus
);

  // Primitive codes presented to the link layer.
  typedef enum logic [3:0] {
    P_NONE    = 4'd0,
    P_SYNC    = 4'd1,
    P_X_RDY   = 4'd2,
    P_R_RDY   = 4'd3,
    P_SOF     = 4'd4,
    P_EOF     = 4'd5,
    P_HOLD    = 4'd6,
    P_HOLDA   = 4'd7,
    P_R_IP    = 4'd8,
    P_R_OK    = 4'd9,
    P_R_ERR   = 4'd10,
    P_WTRM    = 4'd11,
    P_DMAT    = 4'd12,
    P_PMREQ   = 4'd13,
    P_UNKNOWN = 4'd15
  } prim_e;

  // Full 32-bit primitive encodings (byte0 is the K28.x character).
  localparam logic [31:0] W_ALIGN   = 32'h7B4A_4ABC;
  localparam logic [31:0] W_SYNC    = 32'hB5B5_957C;
  localparam logic [31:0] W_X_RDY   = 32'h5757_B57C;
  localparam logic [31:0] W_R_RDY   = 32'h4A4A_957C;
  localparam logic [31:0] W_SOF     = 32'h3737_B57C;
  localparam logic [31:0] W_EOF     = 32'hD5D5_B57C;
  localparam logic [31:0] W_HOLD    = 32'hD5D5_AA7C;
  localparam logic [31:0] W_HOLDA   = 32'h9595_AA7C;
  localparam logic [31:0] W_R_IP    = 32'h5555_B57C;
  localparam logic [31:0] W_R_OK    = 32'h3535_B57C;
  localparam logic [31:0] W_R_ERR   = 32'h5656_B57C;
  localparam logic [31:0] W_WTRM    = 32'h5858_B57C;
  localparam logic [31:0] W_DMAT    = 32'h3636_B57C;
  localparam logic [31:0] W_PMREQ_P = 32'h1717_B57C;
  localparam logic [31:0] W_PMREQ_S = 32'h7575_957C;
  localparam logic [31:0] W_CONT    = 32'h9999_AA7C;

  // Only primitives that the transmitter may legally repeat with CONT can
  // be expanded. SOF/EOF/DMAT are single-shot, and NONE/UNKNOWN give no
  // usable history, so a CONT after any of those is a protocol error.
  function automatic logic cont_allowed(input prim_e p);
    case (p)
      P_SYNC, P_X_RDY, P_R_RDY, P_HOLD, P_HOLDA,
      P_R_IP, P_R_OK, P_R_ERR, P_WTRM, P_PMREQ: cont_allowed = 1'b1;
      default:                                  cont_allowed = 1'b0;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Decode of the current input dword
  // -------------------------------------------------------------------------
  prim_e k_code;
  logic  is_align;
  logic  is_cont;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    k_code   = P_UNKNOWN;
    is_align = 1'b0;
    is_cont  = 1'b0;
    case (bus.rxdata)
      W_ALIGN:             is_align = 1'b1;
      W_CONT:              is_cont  = 1'b1;
      W_SYNC:              k_code   = P_SYNC;
      W_X_RDY:             k_code   = P_X_RDY;
      W_R_RDY:             k_code   = P_R_RDY;
      W_SOF:               k_code   = P_SOF;
      W_EOF:               k_code   = P_EOF;
      W_HOLD:              k_code   = P_HOLD;
      W_HOLDA:             k_code   = P_HOLDA;
      W_R_IP:              k_code   = P_R_IP;
      W_R_OK:              k_code   = P_R_OK;
      W_R_ERR:             k_code   = P_R_ERR;
      W_WTRM:              k_code   = P_WTRM;
      W_DMAT:              k_code   = P_DMAT;
      W_PMREQ_P, W_PMREQ_S: k_code  = P_PMREQ;
      default:             k_code   = P_UNKNOWN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered state and outputs
  // -------------------------------------------------------------------------
  prim_e                   last_prim;
  logic                    cont_active_q;
  logic                    prim_vld_q;
  prim_e                   prim_code_q;
  logic                    data_vld_q;
  logic [31:0]             data_out_q;
  logic                    prim_err_q;
  logic [C_ERRCNT_W-1:0]   err_cnt_q;
  logic [C_ALIGNCNT_W-1:0] align_cnt_q;

  logic last_ok;
  logic k_seen;
  logic err_now;

  assign last_ok = cont_allowed(last_prim);
  assign k_seen  = bus.linkup && bus.rxdatak;

  // A decode error is either a CONT with no repeatable history or a K dword
  // that matches nothing. Computed once so the pulse and the counter agree.
  assign err_now = k_seen && !is_align &&
                   ((is_cont && !last_ok) || (!is_cont && k_code == P_UNKNOWN));

  always_ff @(posedge clk_75m) begin
    if (host_rst) begin
      last_prim     <= P_NONE;
      cont_active_q <= 1'b0;
      prim_vld_q    <= 1'b0;
      prim_code_q   <= P_NONE;
      data_vld_q    <= 1'b0;
      data_out_q    <= '0;
      prim_err_q    <= 1'b0;
      err_cnt_q     <= '0;
      align_cnt_q   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // right-hand side reads the pre-edge value, whatever the statement order.
      prim_vld_q  <= 1'b0;
      prim_code_q <= P_NONE;
      data_vld_q  <= 1'b0;
      prim_err_q  <= err_now;

      if (!bus.linkup) begin
        // Link lost: forget all history so the first dword after linkup
        // returns is decoded from scratch. Counters hold.
        cont_active_q <= 1'b0;
        last_prim     <= P_NONE;
      end else if (!bus.rxdatak) begin
        if (cont_active_q) begin
          // Scrambled junk inside a CONT run stands in for the repeated
          // primitive; it is never passed on as data.
          if (last_ok) begin
            prim_vld_q  <= 1'b1;
            prim_code_q <= last_prim;
          end
        end else begin
          data_vld_q <= 1'b1;
          data_out_q <= bus.rxdata;
        end
      end else if (is_align) begin
        // ALIGN is transparent: CONT run and history are left untouched.
        if (align_cnt_q != '1) begin
          align_cnt_q <= align_cnt_q + C_ALIGNCNT_W'(1);
        end
      end else if (is_cont) begin
        // Enter (or stay in) suppression even for an illegal CONT, so the
        // junk that follows is not mistaken for FIS data.
        cont_active_q <= 1'b1;
        if (last_ok) begin
          prim_vld_q  <= 1'b1;
          prim_code_q <= last_prim;
        end
      end else begin
        prim_vld_q    <= 1'b1;
        prim_code_q   <= k_code;
        last_prim     <= k_code;
        cont_active_q <= 1'b0;
      end

      if (err_now && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + C_ERRCNT_W'(1);
      end
    end
  end

  assign bus.prim_vld    = prim_vld_q;
  assign bus.prim_code   = prim_code_q;
  assign bus.data_vld    = data_vld_q;
  assign bus.data_out    = data_out_q;
  assign bus.cont_active = cont_active_q;
  assign bus.prim_err    = prim_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.align_cnt   = align_cnt_q;

endmodule
